// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_rv.sv
// Banked 1rw sync memory, bit write mask, valid/ready in, valid/yumi out.
// Read data is held until consumed; optionally latched after consumption.
module bsg_mem_1rw_sync_mask_write_bit_banked_rv #(
  parameter int width_p           = 64,
  parameter int els_p             = 256,
  parameter int num_width_bank_p  = 2,
  parameter int num_depth_bank_p  = 2,
  parameter int latch_last_read_p = 1,
  parameter int addr_width_lp     = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i
);

  localparam int bank_w_lp   = width_p / num_width_bank_p;
  localparam int bank_els_lp = els_p / num_depth_bank_p;
  localparam int lbank_w_lp  =
    (bank_els_lp == 1) ? 1 : $clog2(bank_els_lp);
  localparam int dsel_w_lp   =
    (num_depth_bank_p == 1) ? 1 : $clog2(num_depth_bank_p);

  logic                     v_r;
  logic                     accept;
  logic                     rd_accept;
  logic                     addr_ok;
  logic [dsel_w_lp-1:0]     dsel;
  logic [dsel_w_lp-1:0]     dsel_r;
  logic [addr_width_lp-1:0] off;
  logic [addr_width_lp-1:0] laddr_full;
  logic [lbank_w_lp-1:0]    laddr;
  logic [width_p-1:0]       rd_data;
  logic [bank_w_lp-1:0]     bank_q [num_depth_bank_p][num_width_bank_p];

  assign addr_ok   = {1'b0, addr_i} < (addr_width_lp+1)'(els_p);
  assign ready_o   = reset_n_i & (~v_r | yumi_i);
  assign accept    = v_i & ready_o;
  assign rd_accept = accept & ~w_i;
  assign v_o       = v_r;

  // Split the word address into depth-bank select and bank-local address.
  always_comb begin
    dsel = '0;
    off  = '0;
    for (int i = 1; i < num_depth_bank_p; i++) begin
      if (addr_i >= addr_width_lp'(i * bank_els_lp)) begin
        dsel = dsel_w_lp'(i);
        off  = addr_width_lp'(i * bank_els_lp);
      end
    end
    laddr_full = addr_i - off;
  end

  assign laddr = laddr_full[lbank_w_lp-1:0];

  if (lbank_w_lp < addr_width_lp) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^laddr_full[addr_width_lp-1:lbank_w_lp];
  end

  // Response valid and the depth bank that owns the pending read.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r    <= 1'b0;
      dsel_r <= '0;
    end else if (rd_accept) begin
      v_r    <= 1'b1;
      dsel_r <= dsel;
    end else if (yumi_i) begin
      v_r    <= 1'b0;
    end
  end

  for (genvar d = 0; d < num_depth_bank_p; d++) begin : g_d
    for (genvar w = 0; w < num_width_bank_p; w++) begin : g_w
      logic [bank_w_lp-1:0] mem [bank_els_lp];
      logic [bank_w_lp-1:0] q;
      logic [bank_w_lp-1:0] wd;
      logic [bank_w_lp-1:0] wm;
      logic                 en;

      assign en = accept & addr_ok & (dsel == dsel_w_lp'(d));
      assign wd = data_i[w*bank_w_lp +: bank_w_lp];
      assign wm = w_mask_i[w*bank_w_lp +: bank_w_lp];

      // Behavioural bank: masked write, or registered read.
      always_ff @(posedge clk_i) begin
        if (en) begin
          if (w_i)
            mem[laddr] <= (mem[laddr] & ~wm) | (wd & wm);
          else
            q <= mem[laddr];
        end
      end

      assign bank_q[d][w] = q;
    end
  end

  // Pick the width slices of the bank that served the last read.
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < num_width_bank_p; w++)
      rd_data[w*bank_w_lp +: bank_w_lp] = bank_q[dsel_r][w];
  end

  if (latch_last_read_p != 0) begin : g_latch
    logic [width_p-1:0] last_r;

    // Keep the consumed word so later bank traffic cannot disturb data_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
        last_r <= '0;
      else if (v_r & yumi_i)
        last_r <= rd_data;
    end

    assign data_o = v_r ? rd_data : last_r;
  end else begin : g_nolatch
    assign data_o = rd_data;
  end

  // Flag illegal use in simulation.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(v_i && !addr_ok))
        else $error("addr_i out of range");
      assert (!(yumi_i && !v_r))
        else $error("yumi_i without v_o");
    end
  end

endmodule
